// File: rtl/gpio_cfg_serial_loader.sv
// GPIO pad configuration loader: keeps one configuration word per pad and,
// on request, shifts the whole array down the daisy-chained GPIO control
// blocks (last pad first, MSB first), then strobes serial_load.
module gpio_cfg_serial_loader #(
  parameter int                  NPADS       = 38,
  parameter int                  CFG_BITS    = 13,
  parameter int                  CLKDIV      = 2,
  parameter logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h0403
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      cfg_wr_en,
  input  logic [(NPADS > 1 ? $clog2(NPADS) : 1)-1:0] cfg_addr,
  input  logic [CFG_BITS-1:0]                       cfg_wr_data,
  output logic [CFG_BITS-1:0]                       cfg_rd_data,
  output logic                                      cfg_wr_err,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      serial_clock,
  output logic                                      serial_data,
  output logic                                      serial_load,
  output logic                                      serial_resetn
);

  localparam int AW = $bits(cfg_addr);
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int DW = (CLKDIV > 1) ? $clog2(2 * CLKDIV) : 1;

  localparam logic [AW-1:0] PAD_LAST  = AW'(NPADS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(2 * CLKDIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLKDIV);
  localparam logic [DW-1:0] LOAD_LAST = DW'(CLKDIV - 1);
  localparam logic [AW:0]   NPADS_W   = (AW + 1)'(NPADS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHAIN_RST,
    S_SHIFT,
    S_LOAD
  } state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         div_q, div_d;
  logic [AW-1:0]         pad_q, pad_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  rst_cnt_q, rst_cnt_d;

  logic [CFG_BITS-1:0]   mem_q [NPADS];

  logic [CFG_BITS-1:0]   rd_q, rd_d;
  logic                  wr_err_q, wr_err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sclk_q, sclk_d;
  logic                  sdata_q, sdata_d;
  logic                  sload_q, sload_d;
  logic                  sresetn_q, sresetn_d;

  logic                  addr_ok;
  logic                  wr_ok;

  assign addr_ok = ({1'b0, cfg_addr} < NPADS_W);

  // Next-state, counter and registered-output decode.
  // Serial outputs are decoded from the next state/counters so every pin
  // comes straight from a flop yet changes in the cycle the FSM moves.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pad_d     = pad_q;
    bit_d     = bit_q;
    rst_cnt_d = rst_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CHAIN_RST;
          rst_cnt_d = 1'b0;
          pad_d     = PAD_LAST;
          bit_d     = BIT_LAST;
          div_d     = '0;
        end
      end
      S_CHAIN_RST: begin
        if (rst_cnt_q) state_d = S_SHIFT;
        else           rst_cnt_d = 1'b1;
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == '0) begin
            if (pad_q == '0) begin
              state_d = S_LOAD;
            end else begin
              pad_d = pad_q - AW'(1);
              bit_d = BIT_LAST;
            end
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_LOAD: begin
        if (div_q == LOAD_LAST) state_d = S_IDLE;
        else                    div_d   = div_q + DW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    wr_ok    = cfg_wr_en && (state_q == S_IDLE) && !start && addr_ok;
    wr_err_d = cfg_wr_en && !wr_ok;

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_LOAD) && (state_d == S_IDLE);
    sclk_d    = (state_d == S_SHIFT) && (div_d >= DIV_HALF);
    sdata_d   = (state_d == S_SHIFT) ? mem_q[pad_d][bit_d] : 1'b0;
    sload_d   = (state_d == S_LOAD);
    sresetn_d = (state_d != S_CHAIN_RST);

    // Read and write share cfg_addr, so an accepted write is the read result.
    if (wr_ok)        rd_d = cfg_wr_data;
    else if (addr_ok) rd_d = mem_q[cfg_addr];
    else              rd_d = '0;
  end

  // FSM state, shift counters and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      pad_q     <= '0;
      bit_q     <= '0;
      rst_cnt_q <= 1'b0;
      rd_q      <= CFG_DEFAULT;
      wr_err_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      sload_q   <= 1'b0;
      sresetn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pad_q     <= pad_d;
      bit_q     <= bit_d;
      rst_cnt_q <= rst_cnt_d;
      rd_q      <= rd_d;
      wr_err_q  <= wr_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      sload_q   <= sload_d;
      sresetn_q <= sresetn_d;
    end
  end

  // Configuration array; writes only land while idle so the transfer sees a frozen snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NPADS; i++) mem_q[i] <= CFG_DEFAULT;
    end else if (wr_ok) begin
      mem_q[cfg_addr] <= cfg_wr_data;
    end
  end

  assign cfg_rd_data   = rd_q;
  assign cfg_wr_err    = wr_err_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign serial_clock  = sclk_q;
  assign serial_data   = sdata_q;
  assign serial_load   = sload_q;
  assign serial_resetn = sresetn_q;

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Scoreboard bench for gpio_cfg_serial_loader: a 4-pad/CLKDIV=1 instance
// checked against an array-and-chain model, plus a 5-pad/CLKDIV=3 instance
// for divider timing and address-bound handling.
module tb_gpio_cfg_serial_loader;

  localparam int CB       = 13;
  localparam logic [CB-1:0] DEF = 13'h0403;
  localparam int NP       = 4;
  localparam int CD       = 1;
  localparam int NBITS    = NP * CB;
  localparam int BUSY_LEN = 2 + NBITS * 2 * CD + CD;
  localparam int NP_B     = 5;
  localparam int CD_B     = 3;
  localparam int BUSY_B   = 2 + NP_B * CB * 2 * CD_B + CD_B;

  typedef struct {
    logic [CB-1:0] rd;
    logic          rd_vld;
    logic          err;
  } chk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A ----------------
  logic          rstA = 1'b1, startA = 1'b0, weA = 1'b0, vA = 1'b0;
  logic [1:0]    addrA = '0;
  logic [CB-1:0] wdA = '0;
  logic [CB-1:0] rdA;
  logic          errA, busyA, doneA, sclkA, sdataA, sloadA, resetnA;

  gpio_cfg_serial_loader #(.NPADS(NP), .CFG_BITS(CB), .CLKDIV(CD), .CFG_DEFAULT(DEF)) dut_a (
    .clock(clk), .reset(rstA), .start(startA), .cfg_wr_en(weA), .cfg_addr(addrA),
    .cfg_wr_data(wdA), .cfg_rd_data(rdA), .cfg_wr_err(errA), .busy(busyA), .done(doneA),
    .serial_clock(sclkA), .serial_data(sdataA), .serial_load(sloadA), .serial_resetn(resetnA)
  );

  // ---------------- DUT B ----------------
  logic          rstB = 1'b1, startB = 1'b0, weB = 1'b0, vB = 1'b0;
  logic [2:0]    addrB = '0;
  logic [CB-1:0] wdB = '0;
  logic [CB-1:0] rdB;
  logic          errB, busyB, doneB, sclkB, sdataB, sloadB, resetnB;

  gpio_cfg_serial_loader #(.NPADS(NP_B), .CFG_BITS(CB), .CLKDIV(CD_B), .CFG_DEFAULT(DEF)) dut_b (
    .clock(clk), .reset(rstB), .start(startB), .cfg_wr_en(weB), .cfg_addr(addrB),
    .cfg_wr_data(wdB), .cfg_rd_data(rdB), .cfg_wr_err(errB), .busy(busyB), .done(doneB),
    .serial_clock(sclkB), .serial_data(sdataB), .serial_load(sloadB), .serial_resetn(resetnB)
  );

  // ---------------- reference model & scoreboard queues ----------------
  logic [CB-1:0]    ref_a [NP];
  logic [CB-1:0]    ref_b [NP_B];
  int               idle_from_a = 0;
  int               idle_from_b = 0;
  chk_t             qa[$];
  chk_t             qb[$];
  logic [NBITS-1:0] snap_q[$];
  logic             end_req = 1'b0;

  // Which clock edges carry a queued expectation, and which were in reset.
  logic tagA = 1'b0, tagB = 1'b0, rstA_s = 1'b1, rstB_s = 1'b1;
  always @(posedge clk) begin
    tagA   <= vA;
    tagB   <= vB;
    rstA_s <= rstA;
    rstB_s <= rstB;
  end

  function automatic logic [NBITS-1:0] pack_a();
    logic [NBITS-1:0] r;
    for (int k = 0; k < NP; k++) r[k*CB +: CB] = ref_a[k];
    return r;
  endfunction

  // One cycle of DUT A stimulus; the model predicts what the next edge yields.
  task automatic stepA(input logic rst, input logic st, input logic we,
                       input logic [1:0] a, input logic [CB-1:0] d);
    chk_t c;
    int   nxt;
    logic idle;
    @(negedge clk);
    rstA = rst; startA = st; weA = we; addrA = a; wdA = d; vA = 1'b1;
    nxt = cyc + 1;
    c.err = 1'b0;
    c.rd_vld = 1'b1;
    if (rst) begin
      for (int k = 0; k < NP; k++) ref_a[k] = DEF;
      idle_from_a = nxt + 1;
      snap_q.delete();
      c.rd = DEF;
    end else begin
      idle = (nxt >= idle_from_a);
      if (we) begin
        if (idle && !st) ref_a[a] = d;
        else             c.err = 1'b1;
      end
      if (st && idle) begin
        snap_q.push_back(pack_a());
        idle_from_a = nxt + 1 + BUSY_LEN;
      end
      c.rd = ref_a[a];
    end
    qa.push_back(c);
  endtask

  task automatic idleA(input int n);
    for (int i = 0; i < n; i++) stepA(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)), '0);
  endtask

  task automatic stepB(input logic rst, input logic st, input logic we,
                       input logic [2:0] a, input logic [CB-1:0] d);
    chk_t c;
    int   nxt;
    logic idle;
    @(negedge clk);
    rstB = rst; startB = st; weB = we; addrB = a; wdB = d; vB = 1'b1;
    nxt = cyc + 1;
    c.err = 1'b0;
    c.rd_vld = (int'(a) < NP_B);
    c.rd = '0;
    if (rst) begin
      for (int k = 0; k < NP_B; k++) ref_b[k] = DEF;
      idle_from_b = nxt + 1;
      c.rd = DEF;
      c.rd_vld = 1'b1;
    end else begin
      idle = (nxt >= idle_from_b);
      if (we) begin
        if (idle && !st && int'(a) < NP_B) ref_b[a] = d;
        else                               c.err = 1'b1;
      end
      if (st && idle) idle_from_b = nxt + 1 + BUSY_B;
      if (int'(a) < NP_B) c.rd = ref_b[a];
    end
    qb.push_back(c);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  chk_t             ca, cbk;
  logic [NBITS-1:0] sr = '0;
  logic [NBITS-1:0] snap;
  int pcnt = 0, blen = 0, rlow = 0, lwid = 0;
  logic p_sclk = 1'b0, p_load = 1'b0, p_busy = 1'b0;
  int blen_b = 0, hirun = 0, lorun = 0;
  logic p_sclk_b = 1'b0, p_busy_b = 1'b0;
  logic end_done = 1'b0;

  always @(negedge clk) begin
    // DUT A: readback and write-error scoreboard
    if (tagA) begin
      if (qa.size() == 0) check("a_queue_depth", 64'(qa.size()), 64'd1);
      else begin
        ca = qa.pop_front();
        if (ca.rd_vld) check("a_rd_data", 64'(rdA), 64'(ca.rd));
        check("a_wr_err", 64'(errA), 64'(ca.err));
      end
    end
    if (rstA_s) begin
      check("a_reset_outputs", 64'({busyA, doneA, sclkA, sdataA, sloadA, resetnA}), 64'd0);
      sr = '0; pcnt = 0; blen = 0; rlow = 0; lwid = 0;
    end else begin
      if (!resetnA) begin
        sr = '0;
        rlow++;
      end else if (rlow != 0) begin
        check("a_chain_reset_len", 64'(rlow), 64'd2);
        rlow = 0;
      end
      if (sclkA) check("a_sclk_guard", 64'({resetnA, sloadA}), 64'd2);
      if (sclkA && !p_sclk) begin
        sr = {sr[NBITS-2:0], sdataA};
        pcnt++;
      end
      if (sloadA) begin
        if (!p_load) begin
          if (snap_q.size() == 0) check("a_load_expected", 64'(snap_q.size()), 64'd1);
          else begin
            snap = snap_q.pop_front();
            for (int k = 0; k < NP; k++)
              check($sformatf("a_pad%0d_word", k), 64'(sr[k*CB +: CB]), 64'(snap[k*CB +: CB]));
          end
          check("a_pulse_count", 64'(pcnt), 64'(NBITS));
          pcnt = 0;
        end
        lwid++;
      end else if (lwid != 0) begin
        check("a_load_width", 64'(lwid), 64'(CD));
        lwid = 0;
      end
      if (busyA) blen++;
      if (doneA || (p_busy && !busyA)) check("a_done_pulse", 64'(doneA), 64'(p_busy && !busyA));
      if (p_busy && !busyA) begin
        check("a_busy_len", 64'(blen), 64'(BUSY_LEN));
        blen = 0;
      end
    end
    p_sclk = sclkA; p_load = sloadA; p_busy = busyA;

    // DUT B: readback/error scoreboard, divider phases, busy length
    if (tagB) begin
      if (qb.size() == 0) check("b_queue_depth", 64'(qb.size()), 64'd1);
      else begin
        cbk = qb.pop_front();
        if (cbk.rd_vld) check("b_rd_data", 64'(rdB), 64'(cbk.rd));
        check("b_wr_err", 64'(errB), 64'(cbk.err));
      end
    end
    if (rstB_s) begin
      blen_b = 0; hirun = 0; lorun = 0;
    end else begin
      if (sclkB) hirun++;
      else if (p_sclk_b) begin
        check("b_sclk_high_phase", 64'(hirun), 64'(CD_B));
        hirun = 0;
      end
      if (busyB && resetnB && !sloadB && !sclkB) lorun++;
      if (sclkB && !p_sclk_b) begin
        check("b_sclk_low_phase", 64'(lorun), 64'(CD_B));
        lorun = 0;
      end
      if (busyB) blen_b++;
      if (doneB || (p_busy_b && !busyB)) check("b_done_pulse", 64'(doneB), 64'(p_busy_b && !busyB));
      if (p_busy_b && !busyB) begin
        check("b_busy_len", 64'(blen_b), 64'(BUSY_B));
        blen_b = 0;
      end
    end
    p_sclk_b = sclkB; p_busy_b = busyB;

    if (end_req && !end_done) begin
      check("a_transfers_outstanding", 64'(snap_q.size()), 64'd0);
      check("a_checks_outstanding", 64'(qa.size()), 64'd0);
      check("b_checks_outstanding", 64'(qb.size()), 64'd0);
      end_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset then a default-content transfer
    repeat (3) stepA(1'b1, 1'b0, 1'b0, 2'd0, '0);
    stepA(1'b0, 1'b1, 1'b0, 2'd0, '0);
    idleA(BUSY_LEN + 2);

    // 2 + 3: distinct words, write-first readback, write dropped mid-transfer
    stepA(1'b0, 1'b0, 1'b1, 2'd0, 13'h1FFF);
    stepA(1'b0, 1'b0, 1'b1, 2'd1, 13'h0000);
    stepA(1'b0, 1'b0, 1'b1, 2'd2, 13'h0AAA);
    stepA(1'b0, 1'b0, 1'b1, 2'd3, 13'h1555);
    for (int k = 0; k < NP; k++) stepA(1'b0, 1'b0, 1'b0, 2'(k), '0);
    stepA(1'b0, 1'b1, 1'b1, 2'd1, 13'h0123);
    idleA(10);
    stepA(1'b0, 1'b0, 1'b1, 2'd2, 13'h0001);
    idleA(BUSY_LEN);
    for (int k = 0; k < NP; k++) stepA(1'b0, 1'b0, 1'b0, 2'(k), '0);

    // 4: reset around bit 20 of the shift
    stepA(1'b0, 1'b1, 1'b0, 2'd0, '0);
    idleA(42);
    repeat (2) stepA(1'b1, 1'b0, 1'b0, 2'd0, '0);
    for (int k = 0; k < NP; k++) stepA(1'b0, 1'b0, 1'b0, 2'(k), '0);

    // 5: random contents, start while busy, start in the done cycle
    for (int k = 0; k < NP; k++) stepA(1'b0, 1'b0, 1'b1, 2'(k), CB'($urandom));
    stepA(1'b0, 1'b1, 1'b0, 2'd0, '0);
    idleA(29);
    stepA(1'b0, 1'b1, 1'b0, 2'd3, '0);
    idleA(BUSY_LEN - 30);
    stepA(1'b0, 1'b1, 1'b1, 2'd0, CB'($urandom));
    idleA(BUSY_LEN + 2);
    @(negedge clk);
    vA = 1'b0;

    // 6: divider 3 and out-of-range address on the 5-pad instance
    repeat (2) stepB(1'b1, 1'b0, 1'b0, 3'd0, '0);
    stepB(1'b0, 1'b0, 1'b1, 3'd2, CB'($urandom));
    stepB(1'b0, 1'b0, 1'b1, 3'd5, 13'h1234);
    for (int k = 0; k < NP_B; k++) stepB(1'b0, 1'b0, 1'b0, 3'(k), '0);
    stepB(1'b0, 1'b1, 1'b0, 3'd0, '0);
    for (int i = 0; i < BUSY_B + 2; i++) stepB(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, NP_B - 1)), '0);
    @(negedge clk);
    vB = 1'b0;

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
